imem_arbiter: RTL
=================

Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: port F (core instruction fetch, read-only) and port D (debug/program loader, read or write).
- Sits between the fetch stage / debug loader and the instruction memory array. Drives the word-aligned address, write enable and write data, and samples the memory's combinational read data.
- Grants at most one access per cycle. Each port gets a registered 1-entry response buffer with valid/ready handshakes.

Parameters:
- WIDTH, 32, data width and full byte-address width.
- ADDR_W, WIDTH-2, word-address width (localparam, not overridable).
- DEPTH_WORDS, 1024, number of implemented memory words; word addresses at or above this are out of range.
- STARVE_LIMIT, 4, consecutive cycles port F may be held off by port D before F is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  ADDR_W  fetch word address
- f_rsp_valid  out  1  fetch response valid
- f_rsp_ready  in  1  fetch consumer takes the response
- f_rsp_data  out  WIDTH  instruction word
- f_rsp_err  out  1  address was out of range
- d_req_valid  in  1  debug request valid
- d_req_ready  out  1  debug request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  ADDR_W  debug word address
- d_req_wdata  in  WIDTH  debug write data
- d_rsp_valid  out  1  debug response valid
- d_rsp_ready  in  1  debug consumer takes the response
- d_rsp_data  out  WIDTH  read data; 0 for writes
- d_rsp_err  out  1  address was out of range
- mem_addr  out  ADDR_W  word address to the memory
- mem_we  out  1  memory write strobe
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  combinational read data from the memory
- grant_dbg  out  1  registered; 1 when the last grant went to D (status/observability)

Behaviour:
- Reset (rst_n low, asynchronous): f/d_rsp_valid=0, rsp_data=0, rsp_err=0, grant_dbg=0, starvation counter=0, round-robin pointer=F. Combinational outputs (req_ready, mem_*) are 0 while in reset.
- Eligibility: a port is eligible when req_valid=1 AND its response buffer is either empty or draining this cycle (rsp_valid & rsp_ready).
- Arbitration (default): D wins over F, except when starve_cnt == STARVE_LIMIT, in which case F wins.
- Starvation counter:
  - Increments when F is eligible and loses; saturates at STARVE_LIMIT.
  - Clears on any F grant, or when F is not eligible.
- Grant cycle (combinational):
  - Winner's req_ready=1; mem_addr = winner's address.
  - mem_we = d_req_we, only on a D grant with an in-range address.
  - mem_wdata = d_req_wdata.
  - With no grant: mem_addr=0, mem_we=0.
- Response: on the next rising edge the winner's buffer loads rsp_valid=1, data=mem_rdata (read) or 0 (write), and err = (addr >= DEPTH_WORDS). Latency from request accept to rsp_valid is exactly 1 cycle.
- Out-of-range address: no memory write occurs, data=0, err=1. The handshake still completes.
- Response hold: rsp_valid stays 1 and rsp_data/err stay stable until rsp_ready=1.
  - A simultaneous drain and new grant yields back-to-back responses, one per cycle.
  - A drain with no new grant clears rsp_valid.
- Request stability: the requester holds req fields stable while req_valid=1 and req_ready=0.
- Reset mid-operation: in-flight responses are discarded and any write is aborted. Requesters must re-issue.
- No combinational path from rsp_ready to mem_we beyond the eligibility term.

Optional Feature:
- Macro IMEM_ARB_RR_EN.
- Defined: round-robin arbitration. The pointer toggles to the other port after each grant, and the loser of a contended cycle wins the next contended cycle. The starvation counter and STARVE_LIMIT are not used.
- Undefined: fixed D-priority with the starvation override, as described in Behaviour.

Decomposition:
- Shared package imem_arb_pkg:
  - port-id enum (PORT_F, PORT_D)
  - response struct {valid, data, err}
  - default STARVE_LIMIT constant
- One natural sub-module: imem_rsp_buf, the 1-entry response register with valid/ready. It is instantiated twice.

Test Plan:
- Single F read: f_req_valid with addr=5, mem[5]=0x00000013 -> f_req_ready in the same cycle; next cycle f_rsp_valid=1, data=0x00000013, err=0.
- Contention: F and D both valid continuously, D reads -> D is granted 4 consecutive cycles, the 5th grant goes to F (STARVE_LIMIT=4), then D again.
- D write then F read: D writes addr=3 data=0xDEADBEEF, then F reads addr=3 -> f_rsp_data=0xDEADBEEF.
- Out of range: D write to addr=1024 -> mem_we stays 0, d_rsp_err=1, d_rsp_data=0; a later read of a neighbouring in-range word is unchanged.
- Backpressure: f_rsp_ready=0 for 3 cycles with f_req_valid=1 -> f_req_ready=0 and f_rsp_data stable. Raising f_rsp_ready -> drain and new grant in the same cycle, then the next response 1 cycle later.
- Reset mid-stream: assert rst_n=0 asynchronously while both rsp_valid=1 -> both rsp_valid drop immediately, and no mem_we occurs during reset.

Source files
------------

// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg
//   Shared types and constants for the instruction-memory arbiter.
//   - port_e      : identifies the requester (fetch or debug)
//   - rsp_t       : contents of a 1-entry response buffer
//   - WORD_W      : instruction word width carried by rsp_t
//   - STARVE_LIMIT_DEFAULT : default number of cycles fetch may lose to debug
package imem_arb_pkg;

    localparam int WORD_W               = 32;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic              err;
    } rsp_t;

endpackage

// File: rtl/imem_rsp_buf.sv
// imem_rsp_buf
//   One-entry registered response buffer with a valid/ready output handshake.
//   A load always wins over a drain, which lets a drain and a new grant in the
//   same cycle produce back-to-back responses.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                write a new response on the next rising edge
//   load_data, load_err response contents to capture
//   rsp_ready           consumer takes the current response
//   rsp_valid/data/err  buffered response
//   free                buffer is empty or draining this cycle
module imem_rsp_buf
    import imem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_err,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              free
);

    rsp_t buf_q;
    rsp_t buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load) begin
            buf_d.valid = 1'b1;
            buf_d.data  = load_data;
            buf_d.err   = load_err;
        end else if (buf_q.valid && rsp_ready) begin
            // Data and err are left as-is; only valid matters once drained.
            buf_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign rsp_valid = buf_q.valid;
    assign rsp_data  = buf_q.data;
    assign rsp_err   = buf_q.err;
    assign free      = !buf_q.valid || rsp_ready;

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares a single-port instruction memory between the fetch port (F,
//   read-only) and the debug/loader port (D, read/write). At most one access
//   is granted per cycle; each port has a registered 1-entry response buffer,
//   so a response appears exactly one cycle after its request is accepted.
//   Word addresses at or above DEPTH_WORDS are answered with err=1, data=0
//   and never write the memory.
//
//   Build option: define IMEM_ARB_RR_EN for round-robin arbitration between
//   F and D. Without it, D has priority and F is forced through after losing
//   STARVE_LIMIT consecutive contended cycles.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   f_req_valid/ready/addr            fetch request
//   f_rsp_valid/ready/data/err        fetch response
//   d_req_valid/ready/we/addr/wdata   debug request
//   d_rsp_valid/ready/data/err        debug response
//   mem_addr/we/wdata, mem_rdata      memory array interface (combinational read)
//   grant_dbg                         1 when the most recent grant went to D
//
//   WIDTH must equal imem_arb_pkg::WORD_W, which sizes the response buffers.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int WIDTH        = WORD_W,
    parameter int DEPTH_WORDS  = 1024,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_req_valid,
    output logic             f_req_ready,
    input  logic [WIDTH-3:0] f_req_addr,
    output logic             f_rsp_valid,
    input  logic             f_rsp_ready,
    output logic [WIDTH-1:0] f_rsp_data,
    output logic             f_rsp_err,
    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic             d_req_we,
    input  logic [WIDTH-3:0] d_req_addr,
    input  logic [WIDTH-1:0] d_req_wdata,
    output logic             d_rsp_valid,
    input  logic             d_rsp_ready,
    output logic [WIDTH-1:0] d_rsp_data,
    output logic             d_rsp_err,
    output logic [WIDTH-3:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             grant_dbg
);

    localparam int              ADDR_W    = WIDTH - 2;
    localparam logic [WIDTH-1:0] DEPTH_LIM = WIDTH'(DEPTH_WORDS);

    logic             f_free, d_free;
    logic             f_elig, d_elig;
    logic             f_favoured;
    logic             f_grant, d_grant;
    logic             f_oor, d_oor;
    logic [WIDTH-1:0] f_load_data, d_load_data;
    logic             grant_dbg_q, grant_dbg_d;

`ifdef IMEM_ARB_RR_EN
    port_e rr_ptr_q, rr_ptr_d;
`else
    localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_q, starve_d;
`endif

    assign f_oor = {2'b00, f_req_addr} >= DEPTH_LIM;
    assign d_oor = {2'b00, d_req_addr} >= DEPTH_LIM;

    // Which port wins when both are eligible in the same cycle.
`ifdef IMEM_ARB_RR_EN
    assign f_favoured = (rr_ptr_q == PORT_F);
`else
    assign f_favoured = (starve_q == STARVE_MAX);
`endif

    // Grants are forced off while reset is asserted so nothing reaches the
    // memory or the requesters during reset.
    always_comb begin
        f_elig  = f_req_valid && f_free;
        d_elig  = d_req_valid && d_free;
        f_grant = 1'b0;
        d_grant = 1'b0;
        if (f_elig && d_elig) begin
            f_grant = f_favoured;
            d_grant = !f_favoured;
        end else begin
            f_grant = f_elig;
            d_grant = d_elig;
        end
        f_grant = f_grant && rst_n;
        d_grant = d_grant && rst_n;
    end

    always_comb begin
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = rst_n ? d_req_wdata : '0;
        f_load_data = f_oor ? '0 : mem_rdata;
        d_load_data = (d_req_we || d_oor) ? '0 : mem_rdata;
        if (f_grant) begin
            mem_addr = f_req_addr;
        end else if (d_grant) begin
            mem_addr = d_req_addr;
            mem_we   = d_req_we && !d_oor;
        end
    end

    assign f_req_ready = f_grant;
    assign d_req_ready = d_grant;

    always_comb begin
        grant_dbg_d = grant_dbg_q;
        if (f_grant) begin
            grant_dbg_d = 1'b0;
        end else if (d_grant) begin
            grant_dbg_d = 1'b1;
        end
`ifdef IMEM_ARB_RR_EN
        // After any grant the other port becomes favoured for the next
        // contended cycle.
        rr_ptr_d = rr_ptr_q;
        if (f_grant) begin
            rr_ptr_d = PORT_D;
        end else if (d_grant) begin
            rr_ptr_d = PORT_F;
        end
`else
        // Counts consecutive contended cycles F has lost, saturating.
        starve_d = '0;
        if (f_elig && !f_grant) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_dbg_q <= 1'b0;
`ifdef IMEM_ARB_RR_EN
            rr_ptr_q    <= PORT_F;
`else
            starve_q    <= '0;
`endif
        end else begin
            grant_dbg_q <= grant_dbg_d;
`ifdef IMEM_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    assign grant_dbg = grant_dbg_q;

    imem_rsp_buf u_f_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (f_grant),
        .load_data (f_load_data),
        .load_err  (f_oor),
        .rsp_ready (f_rsp_ready),
        .rsp_valid (f_rsp_valid),
        .rsp_data  (f_rsp_data),
        .rsp_err   (f_rsp_err),
        .free      (f_free)
    );

    imem_rsp_buf u_d_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (d_grant),
        .load_data (d_load_data),
        .load_err  (d_oor),
        .rsp_ready (d_rsp_ready),
        .rsp_valid (d_rsp_valid),
        .rsp_data  (d_rsp_data),
        .rsp_err   (d_rsp_err),
        .free      (d_free)
    );

endmodule
